debug_console: RTL

- Second-generation memory-mapped debug console on the management bus, serving as the CPU's character I/O port toward the host byte stream.
- Buffers output bytes in a parametrised TX FIFO and input bytes in a parametrised RX FIFO.
- Provides a status register and a control register with selectable blocking or non-blocking writes.
- Drives a level interrupt for RX data available and for TX drained.

---
 rtl/debug_console.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/debug_console.sv
// Memory-mapped debug console: CPU character I/O toward a host byte stream.
// TX FIFO drains to the host, RX FIFO fills from the host, with STATUS/CTRL
// registers, optional blocking writes and a registered level interrupt.
module debug_console #(
    parameter logic [15:0] ADDR_BASE = 16'hFF00,
    parameter logic [15:0] ADDR_MASK = 16'hFFF0,
    parameter int          TX_AW     = 4,
    parameter int          RX_AW     = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fifo_tx_vld,
    output logic [7:0]  fifo_tx_dat,
    input  logic        fifo_tx_rdy,
    input  logic        fifo_rx_vld,
    input  logic [7:0]  fifo_rx_dat,
    output logic        fifo_rx_rdy,
    input  logic        mgmt_req,
    input  logic [31:0] mgmt_adr,
    output logic        mgmt_ack,
    input  logic        mgmt_rwn,
    input  logic [1:0]  mgmt_wen,
    input  logic [31:0] mgmt_txd,
    output logic        mgmt_rxe,
    output logic [31:0] mgmt_rxd,
    output logic        irq
);
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [TX_AW:0] TX_DEPTH = {1'b1, {TX_AW{1'b0}}};
    localparam logic [RX_AW:0] RX_DEPTH = {1'b1, {RX_AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_WAITTX, S_ACK, S_RESP
    } state_t;

    state_t state, state_nxt;
    logic   hold;

    // Request captured in DECODE, used by WAITTX/ACK
    logic       r_rwn;
    logic [1:0] r_sel;
    logic       r_wen0;
    logic [7:0] r_wdat;

    logic [2:0] ctrl;     // [0]=block [1]=rx_ie [2]=tx_ie
    logic       tx_ovf, rx_ovf;
    logic [31:0] rdata, rd_word;

    logic [7:0]       tx_mem [0:(1<<TX_AW)-1];
    logic [TX_AW-1:0] tx_wr, tx_rd;
    logic [TX_AW:0]   tx_count;
    logic [7:0]       rx_mem [0:(1<<RX_AW)-1];
    logic [RX_AW-1:0] rx_wr, rx_rd;
    logic [RX_AW:0]   rx_count;

    logic tx_empty, tx_full, rx_nempty, rx_full;
    logic addr_hit, wr_block, in_ack, bus_wr;
    logic tx_push_req, tx_push, tx_drop, tx_pop;
    logic rx_pop, rx_push, rx_drop, sts_wr, ctrl_wr;

    // Bits of the bus that this block never looks at
    logic unused_bits;
    assign unused_bits = ^{mgmt_adr[31:16], mgmt_adr[1:0], mgmt_wen[1], mgmt_txd[31:8], r_wdat[7:5]};

    assign tx_empty  = (tx_count == '0);
    assign tx_full   = (tx_count == TX_DEPTH);
    assign rx_nempty = (rx_count != '0);
    assign rx_full   = (rx_count == RX_DEPTH);

    assign addr_hit = ((mgmt_adr[15:0] & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
    // A DATA write stalls only when blocking mode is on and TX is full now
    assign wr_block = !mgmt_rwn && (mgmt_adr[3:2] == REG_DATA) && mgmt_wen[0]
                      && ctrl[0] && tx_full;

    assign in_ack      = (state == S_ACK);
    assign bus_wr      = in_ack && !r_rwn && r_wen0;
    assign tx_push_req = bus_wr && (r_sel == REG_DATA);
    // Full is judged before the drain: a same-cycle pop does not rescue a push
    assign tx_push     = tx_push_req && !tx_full;
    assign tx_drop     = tx_push_req && tx_full;
    assign tx_pop      = !tx_empty && fifo_tx_rdy;
    assign rx_pop      = in_ack && r_rwn && (r_sel == REG_DATA) && rx_nempty;
    // A full RX still accepts when the bus frees a slot in the same cycle
    assign rx_push     = fifo_rx_vld && (!rx_full || rx_pop);
    assign rx_drop     = fifo_rx_vld && rx_full && !rx_pop;
    assign sts_wr      = bus_wr && (r_sel == REG_STATUS);
    assign ctrl_wr     = bus_wr && (r_sel == REG_CTRL);

    assign fifo_tx_vld = !tx_empty;
    assign fifo_tx_dat = tx_empty ? 8'h00 : tx_mem[tx_rd];
    assign fifo_rx_rdy = 1'b1;
    assign mgmt_ack    = in_ack;
    assign mgmt_rxe    = (state == S_RESP);
    assign mgmt_rxd    = mgmt_rxe ? rdata : 32'h0;

    // State register plus one-cycle lockout after a completed access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            hold  <= 1'b0;
        end else begin
            state <= state_nxt;
            hold  <= (state == S_ACK) || (state == S_RESP);
        end
    end

    // Next-state logic for the bus handshake
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (mgmt_req && !hold) state_nxt = S_DECODE;
            S_DECODE: begin
                if (!addr_hit)     state_nxt = S_IDLE;
                else if (wr_block) state_nxt = S_WAITTX;
                else               state_nxt = S_ACK;
            end
            S_WAITTX: if (!tx_full) state_nxt = S_ACK;
            S_ACK:    state_nxt = r_rwn ? S_RESP : S_IDLE;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Latch the request fields while decoding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rwn  <= 1'b0;
            r_sel  <= 2'd0;
            r_wen0 <= 1'b0;
            r_wdat <= 8'h00;
        end else if (state == S_DECODE) begin
            r_rwn  <= mgmt_rwn;
            r_sel  <= mgmt_adr[3:2];
            r_wen0 <= mgmt_wen[0];
            r_wdat <= mgmt_txd[7:0];
        end
    end

    // Read mux, sampled at ACK so STATUS reflects pre-side-effect state
    always_comb begin
        rd_word = 32'h0;
        case (r_sel)
            REG_DATA:   rd_word = rx_nempty ? {24'h0, rx_mem[rx_rd]} : 32'h0000_FF00;
            REG_STATUS: rd_word = {8'h0, 8'(tx_count), 8'(rx_count), 3'b0,
                                   tx_ovf, rx_ovf, tx_empty, tx_full, rx_nempty};
            REG_CTRL:   rd_word = {29'h0, ctrl};
            default:    rd_word = 32'h0;
        endcase
    end

    // Read data holding register and control/sticky flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= 32'h0;
            ctrl   <= 3'b001;
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (in_ack && r_rwn) rdata <= rd_word;
            if (ctrl_wr) ctrl <= r_wdat[2:0];
            // Clear first so a same-cycle overflow event wins
            if (sts_wr && r_wdat[4]) tx_ovf <= 1'b0;
            if (sts_wr && r_wdat[3]) rx_ovf <= 1'b0;
            if (tx_drop) tx_ovf <= 1'b1;
            if (rx_drop) rx_ovf <= 1'b1;
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= r_wdat;
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
            else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr] <= fifo_rx_dat;
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
            else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
        end
    end

    // Registered level interrupt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq <= 1'b0;
        else      irq <= (ctrl[1] && rx_nempty) || (ctrl[2] && tx_empty);
    end

endmodule
